// File: rtl/gsim_param_if.sv
// Job-input / result-output bundle for the banded Gauss-Seidel solver.
// master drives b values and accepts x; slave is the solver side.
interface gsim_param_if #(
    parameter int N    = 16,
    parameter int B_W  = 16,
    parameter int X_W  = 32,
    parameter int IT_W = 8
);
    localparam int IW = $clog2(N);

    logic                   in_en;
    logic signed [B_W-1:0]  b_in;
    logic [IT_W-1:0]        iter_max;
    logic [X_W-1:0]         tol;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [X_W-1:0]  x_out;
    logic [IW-1:0]          x_idx;
    logic [IT_W-1:0]        iter_used;
    logic                   converged;

    modport master (
        output in_en, b_in, iter_max, tol, out_ready,
        input  in_ready, out_valid, x_out, x_idx, iter_used, converged
    );

    modport slave (
        input  in_en, b_in, iter_max, tol, out_ready,
        output in_ready, out_valid, x_out, x_idx, iter_used, converged
    );
endinterface

// File: rtl/gsim_param.sv
// In-place Gauss-Seidel solver for a 7-band system (20 / -13 / 6 / -1), one row per cycle,
// with programmable sweep limit and early exit on a max-update tolerance.
module gsim_param #(
    parameter int N    = 16,
    parameter int B_W  = 16,
    parameter int X_W  = 32,
    parameter int FRAC = 16,
    parameter int IT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    gsim_param_if.slave  bus
);
    localparam int RW = $clog2(N);
    localparam int AW = X_W + B_W + 8;
    localparam int PW = AW + 21;
    localparam logic [RW-1:0]        LAST  = RW'(N - 1);
    localparam logic signed [AW-1:0] C13   = AW'(13);
    localparam logic signed [AW-1:0] C6    = AW'(6);
    localparam logic signed [PW-1:0] K_MUL = PW'(838861);

    typedef enum logic [2:0] {S_IDLE, S_IN, S_CALC, S_CHECK, S_OUT} state_t;

    state_t                state_reg, state_next;
    logic [RW-1:0]         cnt_reg, cnt_next;
    logic [RW-1:0]         row_reg, row_next;
    logic [IT_W-1:0]       iter_reg, iter_next;
    logic [IT_W-1:0]       lim_reg, lim_next;
    logic [X_W-1:0]        tol_reg, tol_next;
    logic [X_W-1:0]        maxd_reg, maxd_next;
    logic signed [B_W-1:0] b_reg [N];
    logic signed [B_W-1:0] b_next [N];
    logic signed [X_W-1:0] x_reg [N];
    logic signed [X_W-1:0] x_next [N];
    logic                  in_ready_reg, in_ready_next;
    logic                  out_valid_reg, out_valid_next;
    logic signed [X_W-1:0] x_out_reg, x_out_next;
    logic [RW-1:0]         x_idx_reg, x_idx_next;
    logic [IT_W-1:0]       iter_used_reg, iter_used_next;
    logic                  conv_reg, conv_next;

    // Neighbour taps at distance 1..3; rows outside 0..N-1 read as zero.
    logic signed [X_W-1:0] lo_val [3];
    logic signed [X_W-1:0] hi_val [3];

    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_nb
            assign lo_val[gi-1] = (row_reg >= RW'(gi)) ? x_reg[row_reg - RW'(gi)] : '0;
            assign hi_val[gi-1] = (int'(row_reg) < N - gi) ? x_reg[row_reg + RW'(gi)] : '0;
        end
    endgenerate

    logic signed [AW-1:0]  acc;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  sh;
    logic signed [X_W-1:0] x_old;
    logic signed [X_W-1:0] x_new;
    logic [X_W:0]          diff;
    logic [X_W-1:0]        delta;

    always_comb begin
        x_old = x_reg[row_reg];
        acc   = (AW'(b_reg[row_reg]) <<< FRAC)
              + C13 * (AW'(lo_val[0]) + AW'(hi_val[0]))
              - C6  * (AW'(lo_val[1]) + AW'(hi_val[1]))
              + AW'(lo_val[2]) + AW'(hi_val[2]);
        // 838861 / 2^24 approximates 1/20; the arithmetic shift floors.
        prod  = PW'(acc) * K_MUL;
        sh    = prod >>> 24;
        if ((&sh[PW-1:X_W-1]) || (~|sh[PW-1:X_W-1])) begin
            x_new = sh[X_W-1:0];
        end else begin
            x_new = sh[PW-1] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}};
        end
        diff  = {x_new[X_W-1], x_new} - {x_old[X_W-1], x_old};
        delta = diff[X_W] ? (~diff[X_W-1:0] + 1'b1) : diff[X_W-1:0];
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        row_next       = row_reg;
        iter_next      = iter_reg;
        lim_next       = lim_reg;
        tol_next       = tol_reg;
        maxd_next      = maxd_reg;
        b_next         = b_reg;
        x_next         = x_reg;
        x_out_next     = x_out_reg;
        x_idx_next     = x_idx_reg;
        iter_used_next = iter_used_reg;
        conv_next      = conv_reg;

        case (state_reg)
            S_IDLE: begin
                for (int i = 0; i < N; i++) x_next[i] = '0;
                if (bus.in_en) begin
                    b_next[0]  = bus.b_in;
                    lim_next   = (bus.iter_max == '0) ? IT_W'(1) : bus.iter_max;
                    tol_next   = bus.tol;
                    iter_next  = '0;
                    cnt_next   = RW'(1);
                    state_next = S_IN;
                end
            end
            S_IN: begin
                if (bus.in_en) begin
                    b_next[cnt_reg] = bus.b_in;
                    if (cnt_reg == LAST) begin
                        row_next   = '0;
                        state_next = S_CALC;
                    end else begin
                        cnt_next = cnt_reg + RW'(1);
                    end
                end
            end
            S_CALC: begin
                x_next[row_reg] = x_new;
                maxd_next = ((row_reg == '0) || (delta > maxd_reg)) ? delta : maxd_reg;
                if (row_reg == LAST) begin
                    iter_next  = iter_reg + IT_W'(1);
                    state_next = S_CHECK;
                end else begin
                    row_next = row_reg + RW'(1);
                end
            end
            S_CHECK: begin
                if (maxd_reg <= tol_reg || iter_reg == lim_reg) begin
                    conv_next      = (maxd_reg <= tol_reg);
                    iter_used_next = iter_reg;
                    x_idx_next     = '0;
                    x_out_next     = x_reg[0];
                    state_next     = S_OUT;
                end else begin
                    row_next   = '0;
                    state_next = S_CALC;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (x_idx_reg == LAST) begin
                        x_idx_next = '0;
                        state_next = S_IDLE;
                    end else begin
                        x_idx_next = x_idx_reg + RW'(1);
                        x_out_next = x_reg[x_idx_reg + RW'(1)];
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        in_ready_next  = (state_next == S_IDLE) || (state_next == S_IN);
        out_valid_next = (state_next == S_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            row_reg       <= '0;
            iter_reg      <= '0;
            lim_reg       <= '0;
            tol_reg       <= '0;
            maxd_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            x_out_reg     <= '0;
            x_idx_reg     <= '0;
            iter_used_reg <= '0;
            conv_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            row_reg       <= row_next;
            iter_reg      <= iter_next;
            lim_reg       <= lim_next;
            tol_reg       <= tol_next;
            maxd_reg      <= maxd_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            x_out_reg     <= x_out_next;
            x_idx_reg     <= x_idx_next;
            iter_used_reg <= iter_used_next;
            conv_reg      <= conv_next;
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_reg[gi] <= '0;
                    b_reg[gi] <= '0;
                end else begin
                    x_reg[gi] <= x_next[gi];
                    b_reg[gi] <= b_next[gi];
                end
            end
        end
    endgenerate

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.x_out     = x_out_reg;
    assign bus.x_idx     = x_idx_reg;
    assign bus.iter_used = iter_used_reg;
    assign bus.converged = conv_reg;
endmodule

// File: tb/tb_gsim_param.sv
// Directed + randomized bench for gsim_param against a sweep-level arithmetic model.
module tb_gsim_param;
    localparam int N    = 16;
    localparam int B_W  = 16;
    localparam int X_W  = 32;
    localparam int FRAC = 16;
    localparam int IT_W = 8;
    localparam longint XMAX = 64'sd2147483647;
    localparam longint XMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gsim_param_if #(.N(N), .B_W(B_W), .X_W(X_W), .IT_W(IT_W)) bus ();

    gsim_param #(.N(N), .B_W(B_W), .X_W(X_W), .FRAC(FRAC), .IT_W(IT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks = 0;
    int     failures = 0;
    longint b_vec [N];
    longint mx [N];
    longint rx [N];
    longint rx_prev [N];
    int     m_iters;
    int     m_conv;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint nb(input int j);
        return (j < 0 || j >= N) ? 64'sd0 : mx[j];
    endfunction

    // Solve from an all-zero guess with the update formula applied row by row.
    task automatic model_run(input int im, input longint tl);
        int lim;
        longint acc, y, d, maxd;
        logic signed [127:0] p;
        lim = (im == 0) ? 1 : im;
        for (int i = 0; i < N; i++) mx[i] = 0;
        m_iters = 0;
        m_conv  = 0;
        while (1) begin
            maxd = 0;
            for (int i = 0; i < N; i++) begin
                acc = b_vec[i] * 65536
                    + 13 * (nb(i-1) + nb(i+1))
                    - 6  * (nb(i-2) + nb(i+2))
                    + (nb(i-3) + nb(i+3));
                p = acc;
                p = p * 128'sd838861;
                p = p >>> 24;
                if (p > XMAX)      y = XMAX;
                else if (p < XMIN) y = XMIN;
                else               y = longint'(p);
                d = y - mx[i];
                if (d < 0) d = -d;
                if (d > maxd) maxd = d;
                mx[i] = y;
            end
            m_iters++;
            if (maxd <= tl) begin
                m_conv = 1;
                break;
            end
            if (m_iters == lim) break;
        end
    endtask

    task automatic fill_random(input int mag_bits);
        logic signed [15:0] t16;
        for (int i = 0; i < N; i++) begin
            t16 = 16'($urandom);
            b_vec[i] = t16 >>> (16 - mag_bits);
        end
    endtask

    task automatic run_job(input int im, input longint tl, input bit gaps, input bit rnd_ready, input int abort);
        int cyc;
        int idx;
        model_run(im, tl);
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready, 1);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    bus.in_en = 1'b0;
                    bus.b_in  = 16'($urandom);
                    @(negedge clk);
                end
            end
            bus.in_en = 1'b1;
            bus.b_in  = 16'(b_vec[i]);
            if (i == 0) begin
                bus.iter_max = 8'(im);
                bus.tol      = 32'(tl);
            end else begin
                bus.iter_max = 8'($urandom);
                bus.tol      = 32'($urandom);
            end
            @(negedge clk);
        end
        bus.in_en = 1'b0;
        if (abort > 0) begin
            repeat (abort) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("abort_out_valid", bus.out_valid, 0);
            chk("abort_in_ready", bus.in_ready, 1);
            chk("abort_iter_used", bus.iter_used, 0);
            chk("abort_converged", bus.converged, 0);
            chk("abort_x_out", bus.x_out, 0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 260 * (N + 1)) begin
            bus.in_en = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.b_in  = 16'($urandom);
            @(negedge clk);
            cyc++;
        end
        bus.in_en = 1'b0;
        chk("out_valid_rise", bus.out_valid, 1);
        chk("latency", cyc, m_iters * (N + 1));
        chk("iter_used", bus.iter_used, m_iters);
        chk("converged", bus.converged, m_conv);
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 40 * N) begin
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                chk("x_idx", bus.x_idx, idx);
                chk("x_out", bus.x_out, mx[idx]);
                rx[idx] = bus.x_out;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        chk("all_delivered", idx, N);
        chk("out_valid_drop", bus.out_valid, 0);
        chk("in_ready_back", bus.in_ready, 1);
        chk("iter_used_hold", bus.iter_used, m_iters);
        chk("converged_hold", bus.converged, m_conv);
        $display("job iter_max=%0d tol=%0d gaps=%0d rnd_ready=%0d sweeps=%0d conv=%0d x0=%0d",
                 im, tl, gaps, rnd_ready, m_iters, m_conv, rx[0]);
    endtask

    initial begin
        bus.in_en     = 1'b0;
        bus.b_in      = '0;
        bus.iter_max  = '0;
        bus.tol       = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_x_out", bus.x_out, 0);
        chk("rst_x_idx", bus.x_idx, 0);
        chk("rst_iter_used", bus.iter_used, 0);
        chk("rst_converged", bus.converged, 0);
        rst_n = 1'b1;

        // Hand-computed single sweep with all b = 20.
        for (int i = 0; i < N; i++) b_vec[i] = 20;
        run_job(1, 0, 1'b0, 1'b0, 0);
        chk("b20_x0", rx[0], 65536);
        chk("b20_x1", rx[1], 108134);
        chk("b20_iter_used", bus.iter_used, 1);
        chk("b20_converged", bus.converged, 0);

        for (int i = 0; i < N; i++) b_vec[i] = 0;
        run_job(100, 0, 1'b0, 1'b0, 0);
        chk("zero_iter_used", bus.iter_used, 1);
        chk("zero_converged", bus.converged, 1);

        fill_random(16);
        run_job(100, 0, 1'b0, 1'b0, 0);
        fill_random(8);
        run_job(100, 0, 1'b0, 1'b0, 0);

        fill_random(12);
        run_job(5, 64'h7FFFFFFF, 1'b0, 1'b0, 0);
        chk("loose_tol_conv", bus.converged, 1);
        run_job(0, 64'h7FFFFFFF, 1'b0, 1'b0, 0);
        chk("loose_tol_im0", bus.iter_used, 1);
        run_job(0, 0, 1'b0, 1'b0, 0);
        chk("im0_iter_used", bus.iter_used, 1);

        // Same job with and without stalls must give identical x.
        fill_random(10);
        run_job(30, 2, 1'b0, 1'b0, 0);
        for (int i = 0; i < N; i++) rx_prev[i] = rx[i];
        run_job(30, 2, 1'b1, 1'b1, 0);
        for (int i = 0; i < N; i++) chk("stall_equal", rx[i], rx_prev[i]);

        fill_random(14);
        run_job(100, 0, 1'b0, 1'b0, 7);
        fill_random(9);
        run_job(50, 1, 1'b1, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gsim_param.md
# gsim_param

Parametrised Gauss-Seidel solver for the banded system A·x = b. A has diagonal 20, ±1 off-diagonals −13, ±2 off-diagonals 6, ±3 off-diagonals −1. The block accepts N signed b values, runs up to a run-time-programmable number of in-place sweeps, and exits early once the largest per-sweep update is within a programmable tolerance. It then streams x out under valid/ready backpressure. It is the configurable successor of the fixed 16-unknown / 100-iteration solver in the same datapath.

## Interface
- N, 16: number of unknowns; N ≥ 4.
- B_W, 16: width of signed integer b.
- X_W, 32: width of signed fixed-point x.
- FRAC, 16: fractional bits of x.
- IT_W, 8: width of the iteration-count fields.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_en  in  1  b_in valid; accepted only while in_ready=1.
- b_in  in  B_W  signed b_i, sent in order i = 0..N−1.
- iter_max  in  IT_W  sweep limit; sampled with b_0; 0 is treated as 1.
- tol  in  X_W  unsigned convergence tolerance (x LSBs); sampled with b_0.
- in_ready  out  1  high in IDLE and IN.
- out_valid  out  1  x_out/x_idx valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- x_out  out  X_W  signed x_i, Q(X_W−FRAC).FRAC.
- x_idx  out  clog2(N)  index of x_out.
- iter_used  out  IT_W  sweeps executed; stable while out_valid.
- converged  out  1  1 if exit was by tolerance; stable while out_valid.

## Operation
- States: IDLE → IN → CALC → CHECK → (CALC | OUT) → IDLE.
- IDLE: x[] is cleared to 0 on entry. When in_en is high, the block stores b_0, latches iter_max and tol, and moves to IN with count=1.
- IN: each in_en cycle stores b_count and increments count. Cycles with in_en low are stalls; count holds. After b_{N−1} is stored, the block moves to CALC with row=0.
- CALC: one row per cycle, in place, using the newest x values (true Gauss-Seidel).
  - acc = (b_i << FRAC) + 13(x_{i−1}+x_{i+1}) − 6(x_{i−2}+x_{i+2}) + (x_{i−3}+x_{i+3}).
  - Out-of-range neighbours contribute 0.
  - acc is signed with width X_W+B_W+8, so there is no intermediate overflow.
  - x_new = (acc · 838861) >>> 24 (arithmetic shift, floor), then saturated to the signed X_W range.
  - delta = |x_new − x_i|. maxd = max(maxd, delta). maxd is cleared at row 0.
  - x_i ← x_new.
  - After row N−1: go to CHECK and increment iter_cnt.
- CHECK: 1 cycle.
  - If maxd ≤ tol: converged=1, go to OUT.
  - Else if iter_cnt = max(iter_max,1): converged=0, go to OUT.
  - Else: go to CALC with row=0.
- OUT: presents x_0..x_{N−1} in order. The index advances only on a handshake. After the handshake on index N−1, the block goes to IDLE.
- in_en outside IDLE/IN is ignored. No b value is lost or re-ordered.

## Timing
- Reset values: in_ready=1, out_valid=0, x_out=0, x_idx=0, iter_used=0, converged=0. All internal state, x[], b[] and counters are cleared; state=IDLE.
- All outputs are registered.
- Latency: let the cycle that samples b_{N−1} be t, and k = sweeps run. out_valid first rises at t + k(N+1) + 1.
- The initial guess is all-zero for every job. No data is carried between jobs.
- out_ready low: x_out, x_idx and out_valid hold.
- out_ready may be tied high, giving N consecutive output cycles.
- in_ready goes high one cycle after the final handshake. A new job's b_0 may arrive on that cycle.
- An rst_n assertion in any state aborts the job within the same cycle (asynchronous reset). Outputs take reset values. The job is not resumed.
- iter_used and converged update on CHECK→OUT and hold until the next OUT entry.

## Test plan
- N=16, all b=20, iter_max=1, tol=0 -> out_valid at t+18; x_0=0x00010000; x_1=floor(2162688·838861/2^24)=108134; iter_used=1; converged=0.
- All b=0, iter_max=100, tol=0 -> converged=1, iter_used=1, all x=0.
- Random b, iter_max=100, tol=0 -> x matches a bit-exact C model of the formula, sweep for sweep; iter_used equals the model's value.
- Random b, tol=0x7FFFFFFF -> exit after 1 sweep with converged=1; iter_max=0 behaves exactly like iter_max=1.
- Random out_ready (50%), plus in_en gaps during IN -> every x_i delivered once, in order, with x_idx correct; values identical to a run with no stalls.
- rst_n pulsed low mid-CALC, then a new job -> outputs reset immediately; second job's results match the model with no leftover state.
